cbus_arbiter: RTL
=================

// Module: cbus_arbiter
// PURPOSE
//   Multiplexes the cbus requests of several cache masters onto the single cbus
//   toward the memory/AXI bridge. Typical masters: port 0 = DCache, port 1 = ICache.
//   Grants one master at a time and locks the grant for a whole transaction
//   (single beat or burst) until the beat flagged `last`.
//   Routes the downstream response back to the granted master only.
// PARAMETERS
//   NUM_INPUTS  2  number of upstream masters; must be >= 2
//   ROUND_ROBIN 1  1: round-robin priority, search starts after the last winner
//                  0: fixed priority, lowest index wins
// PORTS
//   clk     in   1                              clock, rising edge
//   reset   in   1                              asynchronous, active-high
//   ireqs   in   NUM_INPUTS x $bits(cbus_req_t)  per-master requests
//   iresps  out  NUM_INPUTS x $bits(cbus_resp_t) per-master responses
//   oreq    out  $bits(cbus_req_t)               request to the memory bridge
//   oresp   in   $bits(cbus_resp_t)              response from the memory bridge
// BEHAVIOUR
// - Reset: state=IDLE, sel=0, last_winner=NUM_INPUTS-1, oreq='0, every iresps[i]='0.
//   Reset is asynchronous: asserting it mid-burst drops oreq.valid in the same cycle.
// - States: IDLE, BUSY. Registers: sel (index of granted master), last_winner.
// - IDLE:
//   - oreq='0 and all iresps='0.
//   - If any ireqs[i].valid: choose a winner, sel<=winner, go to BUSY.
//     - ROUND_ROBIN=1: first valid index scanning from last_winner+1 upward, mod NUM_INPUTS.
//     - ROUND_ROBIN=0: lowest valid index.
//   - Grant latency is one cycle: oreq carries the request in the cycle after it
//     first appears.
// - BUSY:
//   - oreq = ireqs[sel], passed through combinationally (all fields).
//   - iresps[sel] = oresp; iresps[j!=sel] = '0.
//   - oresp.ready && oresp.last: go to IDLE, last_winner<=sel.
//     Earliest re-grant (to any master) is the following cycle.
//   - ireqs[sel].valid==0 before last (master aborted): forward valid=0,
//     go to IDLE, last_winner unchanged.
// - Non-selected masters see ready=0/last=0 and must hold their request stable.
//   The arbiter never drops a waiting request; with round-robin each waiting
//   master is served within NUM_INPUTS transactions.
// - Simultaneous new requests in IDLE: the policy above decides; losers wait.
// - Single-beat transactions (len=MLEN1) complete on their first ready&&last beat.
// - last_winner wraps modulo NUM_INPUTS.
// - oresp is ignored in IDLE.
// STRUCTURE
//   Shared package (common): cbus_req_t, cbus_resp_t, MLEN*/MSIZE*/AXI_BURST_*.
//     Nothing new is added to it.
//   Local to this module: state enum {IDLE,BUSY}; index_t = logic[$clog2(NUM_INPUTS)-1:0].
//   One natural sub-module, rr_select: pure-combinational priority picker,
//     inputs valid vector + start index, outputs winner index + any.
//   FSM and sel/last_winner registers live in always_ff with async reset.
// TESTING
//  1 Reset mid-burst: DCache burst at beat 5 of 16, pulse reset
//    -> oreq.valid=0 that cycle; state IDLE; iresps all 0.
//  2 Lone burst read: port0 valid, addr=0x8000_0040, len=MLEN16
//    -> oreq.valid=1 from cycle 1; 16 ready beats routed to iresps[0];
//       iresps[1] stays 0; IDLE after the last beat.
//  3 Simultaneous requests, ROUND_ROBIN=1 after reset: ports 0 and 1 valid
//    -> port 0 served first; port 1 granted the cycle after port 0's last;
//       a new port 0 request after that waits behind port 1.
//  4 Fixed priority (ROUND_ROBIN=0): port1 busy, port0 arrives mid-burst
//    -> no preemption; port0 granted right after port1's last.
//  5 Uncached single beat: port0 write, size=MSIZE4, strobe=0x0F, len=MLEN1
//    -> oreq fields equal the input exactly; done after one ready&&last.
//  6 Abort: port1 drops valid at beat 3
//    -> oreq.valid=0 same cycle; IDLE next; last_winner unchanged.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus types: request/response structs and the size/length/burst encodings
// used by the cache masters and the memory/AXI bridge.
package cbus_arbiter_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] cbus_data_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // len encodes (beats - 1)
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_type_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        addr_t           addr;
        strobe_t         strobe;
        cbus_data_t      data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic       ready;
        logic       last;
        cbus_data_t data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_rr_select.sv
// Combinational priority picker: first set bit of `valid` at or after `start`,
// wrapping to index 0.
module rr_select #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] winner,
    output logic          any
);

    logic          hi_any;
    logic          lo_any;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // hi_* covers indices >= start, lo_* covers the wrapped-around full range
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (valid[i] && (i >= 32'(start)) && !hi_any) begin
                hi_any = 1'b1;
                hi_idx = IW'(i);
            end
            if (valid[i] && !lo_any) begin
                lo_any = 1'b1;
                lo_idx = IW'(i);
            end
        end
        winner = hi_any ? hi_idx : lo_idx;
        any    = lo_any;
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Arbitrates several cache masters onto one cbus; the grant is held for a whole
// transaction and the downstream response is routed back to the granted master.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 2,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_INPUTS],
    output cbus_resp_t iresps [NUM_INPUTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam int unsigned IW = $clog2(NUM_INPUTS);
    typedef logic [IW-1:0] index_t;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state, state_nxt;
    index_t sel, sel_nxt;
    index_t last_winner, last_winner_nxt;

    logic [NUM_INPUTS-1:0] req_valid;
    index_t                start;
    index_t                winner;
    logic                  any;

    always_comb begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            req_valid[i] = ireqs[i].valid;
        end
    end

    always_comb begin
        if (!ROUND_ROBIN) begin
            start = '0;
        end else if (last_winner == index_t'(NUM_INPUTS - 1)) begin
            start = '0;
        end else begin
            start = last_winner + index_t'(1);
        end
    end

    rr_select #(
        .N  (NUM_INPUTS),
        .IW (IW)
    ) u_rr_select (
        .valid  (req_valid),
        .start  (start),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        state_nxt       = state;
        sel_nxt         = sel;
        last_winner_nxt = last_winner;
        oreq            = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
        end

        case (state)
            IDLE: begin
                if (any) begin
                    sel_nxt   = winner;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                oreq        = ireqs[sel];
                iresps[sel] = oresp;
                // a dropped valid is an abort: release without crediting the winner
                if (!ireqs[sel].valid) begin
                    state_nxt = IDLE;
                end else if (oresp.ready && oresp.last) begin
                    state_nxt       = IDLE;
                    last_winner_nxt = sel;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= '0;
            last_winner <= index_t'(NUM_INPUTS - 1);
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            last_winner <= last_winner_nxt;
        end
    end

endmodule
